// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver control core: state encoding,
// the smallest usable oversampling ratio and the default frame width.
package uart_rx_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int PRESC_MIN = 8;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Bundle of configuration, checker and strobe signals between the UART
// receiver control core and its surroundings (sampler, checkers, pin side).
interface uart_rx_fsm_if #(
   parameter int PRESC_W = 6
);

   logic               rx_in;
   logic               par_en;
   logic [PRESC_W-1:0] prescale;
   logic               strt_glitch;
   logic               par_err;
   logic               stp_err;

   logic [PRESC_W-1:0] edge_cnt;
   logic               dat_samp_en;
   logic               deser_en;
   logic               strt_chk_en;
   logic               par_chk_en;
   logic               stp_chk_en;
   logic               data_valid;
   logic               par_error;
   logic               framing_error;

   // Surrounding logic: drives the line, configuration and checker results
   modport master (
      output rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
      input  edge_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
             stp_chk_en, data_valid, par_error, framing_error
   );

   // Control core: consumes checker results, issues enables and pulses
   modport slave (
      input  rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
      output edge_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
             stp_chk_en, data_valid, par_error, framing_error
   );

endinterface

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversampling edge counter and data-bit counter for the UART receiver.
// The edge counter runs 0..presc-1 while enabled and sits at 0 otherwise;
// the bit counter advances once per bit end while bit_en is high.
module edge_bit_counter
   import uart_rx_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cnt_en,
   input  logic               bit_en,
   input  logic               bit_clr,
   input  logic [PRESC_W-1:0] presc,
   output logic [PRESC_W-1:0] edge_cnt,
   output logic               bit_end,
   output logic               last_data_bit
);

   localparam int BIT_W = $clog2(WIDTH + 1);

   logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;

   assign bit_end       = cnt_en && (edge_cnt_q == (presc - PRESC_W'(1)));
   assign last_data_bit = (bit_cnt_q == BIT_W'(WIDTH - 1));
   assign edge_cnt      = edge_cnt_q;

   // Next edge index: wrap at bit end, park at zero when the frame is idle
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      if (!cnt_en) begin
         edge_cnt_d = '0;
      end else if (bit_end) begin
         edge_cnt_d = '0;
      end else begin
         edge_cnt_d = edge_cnt_q + PRESC_W'(1);
      end
   end

   // Next bit position: cleared outside the data phase, bumped per bit end
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (bit_clr) begin
         bit_cnt_d = '0;
      end else if (bit_en && bit_end) begin
         bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
   end

   // Counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_fsm.sv
// Control FSM of the UART receiver: detects the start edge, sequences the
// sampler, deserializer and checkers, and reports each frame's outcome as
// registered one-cycle pulses.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PRESC_W = 6
) (
   input logic          clk,
   input logic          rst,
   uart_rx_fsm_if.slave bus
);

   logic [2:0]         state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               par_en_q, par_en_d;
   logic               perr_q, perr_d;
   logic               ferr_q, ferr_d;
   logic               data_valid_q, data_valid_d;
   logic               par_error_q, par_error_d;
   logic               framing_error_q, framing_error_d;

   logic               start_now;
   logic               cnt_en;
   logic               bit_end;
   logic               last_data_bit;
   logic [PRESC_W-1:0] edge_cnt;

   logic               dat_samp_en;
   logic               deser_en;
   logic               strt_chk_en;
   logic               par_chk_en;
   logic               stp_chk_en;

   assign start_now = ((state_q == IDLE) || (state_q == DONE)) && !bus.rx_in;
   assign cnt_en    = dat_samp_en;

   edge_bit_counter #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
   ) u_counter (
      .clk           (clk),
      .rst           (rst),
      .cnt_en        (cnt_en),
      .bit_en        (state_q == DATA),
      .bit_clr       (state_q != DATA),
      .presc         (presc_q),
      .edge_cnt      (edge_cnt),
      .bit_end       (bit_end),
      .last_data_bit (last_data_bit)
   );

   // Enables derived only from state and counters, never from rx_in
   always_comb begin
      dat_samp_en = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);
      strt_chk_en = (state_q == START)  && bit_end;
      deser_en    = (state_q == DATA)   && bit_end;
      par_chk_en  = (state_q == PARITY) && bit_end;
      stp_chk_en  = (state_q == STOP)   && bit_end;
   end

   // Frame configuration is frozen at each start so mid-frame changes are ignored
   always_comb begin
      presc_d  = presc_q;
      par_en_d = par_en_q;
      if (start_now) begin
         presc_d  = (bus.prescale < PRESC_W'(PRESC_MIN)) ? PRESC_W'(PRESC_MIN)
                                                         : bus.prescale;
         par_en_d = bus.par_en;
      end
   end

   // State sequencing through the frame
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!bus.rx_in) state_d = START;
         end
         START: begin
            if (bit_end) state_d = bus.strt_glitch ? IDLE : DATA;
         end
         DATA: begin
            if (bit_end && last_data_bit) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) state_d = DONE;
         end
         DONE: begin
            state_d = bus.rx_in ? IDLE : START;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sticky error flags collected during the frame, dropped once reported
   always_comb begin
      perr_d = perr_q;
      ferr_d = ferr_q;
      if (state_q == DONE) begin
         perr_d = 1'b0;
         ferr_d = 1'b0;
      end
      if (par_chk_en && bus.par_err) perr_d = 1'b1;
      if (stp_chk_en && bus.stp_err) ferr_d = 1'b1;
   end

   // Outcome pulses, issued in the cycle after DONE
   always_comb begin
      data_valid_d    = (state_q == DONE) && !perr_q && !ferr_q;
      par_error_d     = (state_q == DONE) && perr_q;
      framing_error_d = (state_q == DONE) && ferr_q;
   end

   // Control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         presc_q         <= '0;
         par_en_q        <= 1'b0;
         perr_q          <= 1'b0;
         ferr_q          <= 1'b0;
         data_valid_q    <= 1'b0;
         par_error_q     <= 1'b0;
         framing_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         presc_q         <= presc_d;
         par_en_q        <= par_en_d;
         perr_q          <= perr_d;
         ferr_q          <= ferr_d;
         data_valid_q    <= data_valid_d;
         par_error_q     <= par_error_d;
         framing_error_q <= framing_error_d;
      end
   end

   assign bus.edge_cnt      = edge_cnt;
   assign bus.dat_samp_en   = dat_samp_en;
   assign bus.deser_en      = deser_en;
   assign bus.strt_chk_en   = strt_chk_en;
   assign bus.par_chk_en    = par_chk_en;
   assign bus.stp_chk_en    = stp_chk_en;
   assign bus.data_valid    = data_valid_q;
   assign bus.par_error     = par_error_q;
   assign bus.framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm. A frame-level reference model derives
// every cycle's expected edge index, enables and pulses from the frame
// timing rules (bit windows of P cycles) and compares on the falling edge.
module tb_uart_rx_fsm;
   import uart_rx_pkg::*;

   localparam int WIDTH   = 8;
   localparam int PRESC_W = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int   checks = 0;
   int   errors = 0;

   logic pend_dv = 1'b0;
   logic pend_pe = 1'b0;
   logic pend_fe = 1'b0;
   int   next_presc = 8;
   logic next_pe = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fsm_if #(.PRESC_W(PRESC_W)) bus ();

   uart_rx_fsm #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Single comparison point: count it, report any difference
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive all DUT inputs for the coming clock edge
   task automatic applyStimulus(input logic rx, input logic gl, input logic pe_err,
                                input logic st_err, input int presc, input logic pen);
      bus.rx_in       = rx;
      bus.strt_glitch = gl;
      bus.par_err     = pe_err;
      bus.stp_err     = st_err;
      bus.prescale    = PRESC_W'(presc);
      bus.par_en      = pen;
   endtask

   function automatic logic [7:0] ctl_vec();
      return {bus.dat_samp_en, bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
              bus.stp_chk_en, bus.data_valid, bus.par_error, bus.framing_error};
   endfunction

   function automatic int rand_presc();
      case ($urandom_range(0, 5))
         0:       return int'($urandom_range(0, 7));
         1:       return 8;
         2:       return 16;
         3:       return 32;
         4:       return 12;
         default: return int'($urandom_range(8, 40));
      endcase
   endfunction

   function automatic int eff_p(input int p);
      return (p < PRESC_MIN) ? PRESC_MIN : p;
   endfunction

   function automatic logic rbit();
      return logic'($urandom_range(0, 1));
   endfunction

   // Compare one cycle; pending outcome pulses belong to this cycle
   task automatic checkCycle(input string tag, input int exp_edge, input logic [4:0] exp_en);
      logic [7:0] exp_ctl;
      exp_ctl = {exp_en, pend_dv, pend_pe, pend_fe};
      pend_dv = 1'b0;
      pend_pe = 1'b0;
      pend_fe = 1'b0;
      checkOutput({tag, ".edge"}, 32'(bus.edge_cnt), 32'(exp_edge));
      checkOutput({tag, ".ctl"}, 32'(ctl_vec()), 32'(exp_ctl));
   endtask

   // Idle line with noisy configuration and checker inputs
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkCycle("idle", 0, 5'b0);
         applyStimulus(1'b1, rbit(), rbit(), rbit(), rand_presc(), rbit());
      end
   endtask

   // One frame; cycle 0 is the first START cycle
   task automatic runFrame(input int presc_cfg, input logic pe_cfg, input logic glitch,
                           input logic perr, input logic ferr, input logic from_done,
                           input logic b2b, input int abort_at);
      int   p, n, last, deser_seen, par_cyc;
      logic samp, strt, deser, parc, stpc;
      logic rx, gl, pe_in, st_in;
      int   pr;
      logic pn;
      p          = eff_p(presc_cfg);
      n          = (2 + WIDTH + int'(pe_cfg)) * p;
      last       = glitch ? p - 1 : n;
      par_cyc    = (WIDTH + 2) * p - 1;
      deser_seen = 0;
      if (!from_done) begin
         @(negedge clk);
         checkCycle("pre", 0, 5'b0);
         applyStimulus(1'b0, rbit(), rbit(), rbit(), presc_cfg, pe_cfg);
      end
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         samp  = (c < n);
         strt  = (c == p - 1);
         deser = (c >= p) && (c < (WIDTH + 1) * p) && ((c % p) == p - 1);
         parc  = pe_cfg && (c == par_cyc);
         stpc  = (c == n - 1);
         if (bus.deser_en) deser_seen++;
         checkCycle($sformatf("frm.c%0d", c), samp ? (c % p) : 0,
                    {samp, deser, strt, parc, stpc});
         if (c == abort_at) begin
            rst = 1'b1;
            #1;
            checkOutput("abort.edge", 32'(bus.edge_cnt), 32'd0);
            checkOutput("abort.ctl", 32'(ctl_vec()), 32'd0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0);
            #2;
            rst = 1'b0;
            return;
         end
         rx    = (c == n) ? !b2b : rbit();
         gl    = (c == p - 1) ? glitch : rbit();
         pe_in = (c == par_cyc) ? perr : rbit();
         st_in = (c == n - 1) ? ferr : rbit();
         pr    = (c == n && b2b) ? next_presc : rand_presc();
         pn    = (c == n && b2b) ? next_pe : rbit();
         applyStimulus(rx, gl, pe_in, st_in, pr, pn);
      end
      checkOutput("deser_cnt", 32'(deser_seen), glitch ? 32'd0 : 32'(WIDTH));
      if (!glitch) begin
         pend_pe = pe_cfg && perr;
         pend_fe = ferr;
         pend_dv = !(pe_cfg && perr) && !ferr;
      end
   endtask

   initial begin
      int   pr, fd, b2b, gl;
      logic pn;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0);
      // Reset held with the line low: nothing may start
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkCycle("reset", 0, 5'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idleCycles(2);

      runFrame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      idleCycles(3);
      runFrame(16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      idleCycles(3);
      runFrame(8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      idleCycles(3);
      next_presc = 8;
      next_pe    = 1'b1;
      runFrame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      runFrame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      idleCycles(3);
      runFrame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5 * 8 + 2);
      idleCycles(3);
      runFrame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      idleCycles(3);
      runFrame(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      idleCycles(3);
      runFrame(8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
      idleCycles(3);
      runFrame(16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      idleCycles(3);

      // Randomized frames, including chains of back-to-back frames
      fd = 0;
      for (int k = 0; k < 12; k++) begin
         if (fd != 0) begin
            pr = next_presc;
            pn = next_pe;
         end else begin
            pr = rand_presc();
            pn = rbit();
         end
         gl  = ($urandom_range(0, 5) == 0) ? 1 : 0;
         b2b = (gl == 0 && k != 11) ? int'($urandom_range(0, 1)) : 0;
         if (b2b != 0) begin
            next_presc = rand_presc();
            next_pe    = rbit();
         end
         runFrame(pr, pn, logic'(gl), rbit(), rbit(), logic'(fd), logic'(b2b), -1);
         fd = b2b;
         if (b2b == 0) idleCycles(2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
